// File: rtl/ks_add_sched.sv
// ks_add_sched: round-robin scheduler that shares one pipelined 32-bit adder
// among NREQ requesters. It picks one requester per cycle, registers that
// requester's operands into the adder, follows the operation through a tag
// pipeline matched to the adder latency, and returns the sum and carry-out to
// the requester that issued it. Subtraction is done as A + ~B + 1.
//
// Ports
//   i_clk, i_rst_n         clock (rising edge), asynchronous active-low reset
//   i_req[NREQ]            per-requester request level, held until granted
//   i_a, i_b[NREQ*32]      operands, requester k at bits [32k+31:32k]
//   i_sub[NREQ]            1 = A-B, 0 = A+B
//   i_hold                 blocks new grants; in-flight operations still drain
//   o_gnt[NREQ]            one-hot combinational grant
//   o_add_a, o_add_b       registered adder operands
//   o_add_cin, o_add_vld   registered adder carry-in and operand valid
//   i_add_sum, i_add_cout  adder result, LAT cycles after o_add_vld
//   o_res, o_cout          registered result and raw adder carry-out
//   o_res_vld[NREQ]        one-hot registered owner of o_res
//   o_busy                 registered: any operation in flight
module ks_add_sched #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned LAT  = 7
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [NREQ-1:0]   i_req,
  input  logic [NREQ*32-1:0] i_a,
  input  logic [NREQ*32-1:0] i_b,
  input  logic [NREQ-1:0]   i_sub,
  input  logic              i_hold,
  output logic [NREQ-1:0]   o_gnt,
  output logic [31:0]       o_add_a,
  output logic [31:0]       o_add_b,
  output logic              o_add_cin,
  output logic              o_add_vld,
  input  logic [31:0]       i_add_sum,
  input  logic              i_add_cout,
  output logic [31:0]       o_res,
  output logic              o_cout,
  output logic [NREQ-1:0]   o_res_vld,
  output logic              o_busy
);

  localparam int unsigned IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [IDW-1:0]         rr_q;
  logic [IDW-1:0]         rr_d;
  logic                   gnt_any;
  logic [IDW-1:0]         gnt_id;
  logic [IDW-1:0]         scan_idx;

  logic [31:0]            sel_a;
  logic [31:0]            sel_b;
  logic                   sel_sub;

  logic [31:0]            add_a_q;
  logic [31:0]            add_b_q;
  logic                   add_cin_q;
  logic                   add_vld_q;

  // Stage 0 holds the operation that is on o_add_* this cycle; stage LAT lines
  // up with the adder result on i_add_sum.
  logic [LAT:0]           tag_vld_q;
  logic [LAT:0][IDW-1:0]  tag_id_q;

  logic [31:0]            res_q;
  logic                   cout_q;
  logic [NREQ-1:0]        res_vld_q;
  logic                   busy_q;

  // Search upward from rr, wrapping; the first pending request wins.
  always_comb begin
    gnt_any  = 1'b0;
    gnt_id   = '0;
    scan_idx = '0;
    if (!i_hold) begin
      for (int unsigned i = 0; i < NREQ; i++) begin
        scan_idx = IDW'((32'(rr_q) + i) % NREQ);
        if (!gnt_any && i_req[scan_idx]) begin
          gnt_any = 1'b1;
          gnt_id  = scan_idx;
        end
      end
    end
  end

  always_comb begin
    rr_d = rr_q;
    if (gnt_any) begin
      rr_d = (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + IDW'(1);
    end
  end

  assign o_gnt = gnt_any ? (NREQ'(1) << gnt_id) : '0;

  always_comb begin
    sel_a   = i_a[32*gnt_id +: 32];
    sel_b   = i_b[32*gnt_id +: 32];
    sel_sub = i_sub[gnt_id];
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rr_q      <= '0;
      add_a_q   <= '0;
      add_b_q   <= '0;
      add_cin_q <= 1'b0;
      add_vld_q <= 1'b0;
      tag_vld_q <= '0;
      tag_id_q  <= '0;
      res_q     <= '0;
      cout_q    <= 1'b0;
      res_vld_q <= '0;
      busy_q    <= 1'b0;
    end else begin
      rr_q      <= rr_d;
      add_vld_q <= gnt_any;
      // Operand registers keep their last value when nothing is issued.
      if (gnt_any) begin
        add_a_q   <= sel_a;
        add_b_q   <= sel_sub ? ~sel_b : sel_b;
        add_cin_q <= sel_sub;
      end

      tag_vld_q <= {tag_vld_q[LAT-1:0], gnt_any};
      tag_id_q  <= {tag_id_q[LAT-1:0], gnt_id};

      if (tag_vld_q[LAT]) begin
        res_q     <= i_add_sum;
        cout_q    <= i_add_cout;
        res_vld_q <= NREQ'(1) << tag_id_q[LAT];
      end else begin
        res_vld_q <= '0;
      end

      busy_q <= add_vld_q | (|tag_vld_q);
    end
  end

  assign o_add_a   = add_a_q;
  assign o_add_b   = add_b_q;
  assign o_add_cin = add_cin_q;
  assign o_add_vld = add_vld_q;
  assign o_res     = res_q;
  assign o_cout    = cout_q;
  assign o_res_vld = res_vld_q;
  assign o_busy    = busy_q;

endmodule

// File: tb/tb_ks_add_sched.sv
// Directed bench for ks_add_sched. The bench stands in for the pipelined adder
// with a plain LAT-deep delay line of 33-bit sums.
module tb_ks_add_sched;

  localparam int NREQ = 4;
  localparam int LAT  = 7;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req;
  logic [NREQ*32-1:0] a_bus;
  logic [NREQ*32-1:0] b_bus;
  logic [NREQ-1:0]   sub;
  logic              hold;
  logic [NREQ-1:0]   gnt;
  logic [31:0]       add_a;
  logic [31:0]       add_b;
  logic              add_cin;
  logic              add_vld;
  logic [31:0]       add_sum;
  logic              add_cout;
  logic [31:0]       res;
  logic              cout;
  logic [NREQ-1:0]   res_vld;
  logic              busy;

  int n_chk  = 0;
  int n_fail = 0;

  ks_add_sched #(.NREQ(NREQ), .LAT(LAT)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_req      (req),
    .i_a        (a_bus),
    .i_b        (b_bus),
    .i_sub      (sub),
    .i_hold     (hold),
    .o_gnt      (gnt),
    .o_add_a    (add_a),
    .o_add_b    (add_b),
    .o_add_cin  (add_cin),
    .o_add_vld  (add_vld),
    .i_add_sum  (add_sum),
    .i_add_cout (add_cout),
    .o_res      (res),
    .o_cout     (cout),
    .o_res_vld  (res_vld),
    .o_busy     (busy)
  );

  always #5 clk = ~clk;

  // Adder stand-in: result of the operands seen in cycle c appears in c+LAT.
  logic [32:0] pipe [LAT];
  always @(posedge clk) begin
    pipe[0] <= {1'b0, add_a} + {1'b0, add_b} + {32'd0, add_cin};
    for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
  end
  assign add_sum  = pipe[LAT-1][31:0];
  assign add_cout = pipe[LAT-1][32];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int k, input logic [31:0] a, input logic [31:0] b,
                        input logic s);
    a_bus[32*k +: 32] = a;
    b_bus[32*k +: 32] = b;
    sub[k]            = s;
  endtask

  task automatic test_reset();
    int stray;
    rst_n = 1'b0; req = '0; hold = 1'b0; a_bus = '0; b_bus = '0; sub = '0;
    tick(); tick();
    n_chk++; if ({add_a, add_b, res} !== 96'd0) begin n_fail++;
      $display("FAIL reset_data: got %h %h %h required 0 0 0", add_a, add_b, res); end
    n_chk++; if ({add_cin, cout, add_vld, res_vld, busy} !== 8'd0) begin n_fail++;
      $display("FAIL reset_ctrl: got %b required 00000000", {add_cin, cout, add_vld, res_vld, busy}); end
    rst_n = 1'b1;
    tick();
    // Three ops in flight (requesters 1,2,3), then reset in the middle.
    set_op(1, 32'h11, 32'h1, 1'b0);
    set_op(2, 32'h22, 32'h2, 1'b1);
    set_op(3, 32'h33, 32'h3, 1'b0);
    req = 4'b1110;
    tick(); tick(); tick();
    req = '0;
    #1;
    n_chk++; if (busy !== 1'b1) begin n_fail++;
      $display("FAIL reset_busy_before: got %b required 1", busy); end
    rst_n = 1'b0;
    #1;
    n_chk++; if ({add_a, add_b, res, add_cin, cout, add_vld, res_vld, busy} !== 104'd0) begin
      n_fail++; $display("FAIL reset_async: got %h required 0",
                         {add_a, add_b, res, add_cin, cout, add_vld, res_vld, busy}); end
    tick(); tick();
    rst_n = 1'b1;
    stray = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (res_vld !== '0) stray++;
    end
    n_chk++; if (stray !== 0) begin n_fail++;
      $display("FAIL reset_dropped: got %0d results required 0", stray); end
    set_op(0, 32'h5, 32'h6, 1'b0);
    req = 4'b1111;
    #1;
    n_chk++; if (gnt !== 4'b0001) begin n_fail++;
      $display("FAIL reset_first_gnt: got %b required 0001", gnt); end
    tick();
    req = '0;
    for (int i = 0; i < 10; i++) tick();
  endtask

  task automatic test_single_add();
    int early;
    set_op(2, 32'h7FFF_FFFF, 32'h1, 1'b0);
    req = 4'b0100;
    #1;
    n_chk++; if (gnt !== 4'b0100) begin n_fail++;
      $display("FAIL add_gnt: got %b required 0100", gnt); end
    tick();
    req = '0;
    n_chk++; if ({add_vld, add_cin, add_a, add_b} !== {1'b1, 1'b0, 32'h7FFF_FFFF, 32'h1}) begin
      n_fail++; $display("FAIL add_issue: got %b %b %h %h required 1 0 7fffffff 00000001",
                         add_vld, add_cin, add_a, add_b); end
    early = 0;
    for (int i = 0; i < 7; i++) begin
      tick();
      if (res_vld !== '0) early++;
    end
    n_chk++; if (early !== 0) begin n_fail++;
      $display("FAIL add_early: got %0d early results required 0", early); end
    tick();
    n_chk++; if ({res_vld, res, cout} !== {4'b0100, 32'h8000_0000, 1'b0}) begin n_fail++;
      $display("FAIL add_result: got %b %h %b required 0100 80000000 0", res_vld, res, cout); end
    tick();
    n_chk++; if (res_vld !== '0) begin n_fail++;
      $display("FAIL add_pulse: got %b required 0000", res_vld); end
  endtask

  task automatic test_subtract();
    logic [31:0] va [2] = '{32'd5, 32'd7};
    logic [31:0] vb [2] = '{32'd7, 32'd5};
    logic [31:0] vr [2] = '{32'hFFFF_FFFE, 32'd2};
    logic        vc [2] = '{1'b0, 1'b1};
    for (int v = 0; v < 2; v++) begin
      set_op(1, va[v], vb[v], 1'b1);
      req = 4'b0010;
      #1;
      n_chk++; if (gnt !== 4'b0010) begin n_fail++;
        $display("FAIL sub_gnt%0d: got %b required 0010", v, gnt); end
      tick();
      req = '0;
      n_chk++; if ({add_b, add_cin} !== {~vb[v], 1'b1}) begin n_fail++;
        $display("FAIL sub_issue%0d: got %h %b required %h 1", v, add_b, add_cin, ~vb[v]); end
      for (int i = 0; i < 8; i++) tick();
      n_chk++; if ({res_vld, res, cout} !== {4'b0010, vr[v], vc[v]}) begin n_fail++;
        $display("FAIL sub_result%0d: got %b %h %b required 0010 %h %b",
                 v, res_vld, res, cout, vr[v], vc[v]); end
      tick();
    end
  endtask

  task automatic test_carry_chain();
    set_op(3, 32'hFFFF_FFFF, 32'h1, 1'b0);
    req = 4'b1000;
    #1;
    n_chk++; if (gnt !== 4'b1000) begin n_fail++;
      $display("FAIL carry_gnt: got %b required 1000", gnt); end
    tick();
    req = '0;
    for (int i = 0; i < 8; i++) tick();
    n_chk++; if ({res_vld, res, cout} !== {4'b1000, 32'h0, 1'b1}) begin n_fail++;
      $display("FAIL carry_result: got %b %h %b required 1000 00000000 1", res_vld, res, cout); end
    tick();
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < NREQ; k++) set_op(k, 32'(k), 32'h100, 1'b0);
    req = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      #1;
      n_chk++; if (gnt !== 4'(1 << (i % 4))) begin n_fail++;
        $display("FAIL b2b_gnt%0d: got %b required %b", i, gnt, 4'(1 << (i % 4))); end
      tick();
    end
    req = '0;
    tick();
    for (int i = 0; i < 8; i++) begin
      n_chk++;
      if ({res_vld, res, cout} !== {4'(1 << (i % 4)), 32'h100 + 32'(i % 4), 1'b0}) begin
        n_fail++; $display("FAIL b2b_res%0d: got %b %h %b required %b %h 0", i, res_vld, res,
                           cout, 4'(1 << (i % 4)), 32'h100 + 32'(i % 4)); end
      tick();
    end
    n_chk++; if (res_vld !== '0) begin n_fail++;
      $display("FAIL b2b_tail: got %b required 0000", res_vld); end
  endtask

  task automatic test_hold();
    int leaked;
    set_op(0, 32'h10, 32'h20, 1'b0);
    set_op(1, 32'h1000, 32'h234, 1'b0);
    req  = 4'b0011;
    hold = 1'b0;
    #1;
    n_chk++; if (gnt !== 4'b0001) begin n_fail++;
      $display("FAIL hold_first_gnt: got %b required 0001", gnt); end
    tick();
    hold   = 1'b1;
    leaked = 0;
    for (int i = 1; i <= 11; i++) begin
      #1;
      if (gnt !== '0) leaked++;
      if (i == 9) begin
        n_chk++; if ({res_vld, res, busy} !== {4'b0001, 32'h30, 1'b1}) begin n_fail++;
          $display("FAIL hold_drain: got %b %h %b required 0001 00000030 1", res_vld, res, busy); end
      end
      if (i == 10) begin
        n_chk++; if ({res_vld, busy} !== {4'b0000, 1'b0}) begin n_fail++;
          $display("FAIL hold_busy_fall: got %b %b required 0000 0", res_vld, busy); end
      end
      tick();
    end
    n_chk++; if (leaked !== 0) begin n_fail++;
      $display("FAIL hold_no_gnt: got %0d grants required 0", leaked); end
    hold = 1'b0;
    #1;
    n_chk++; if (gnt !== 4'b0010) begin n_fail++;
      $display("FAIL hold_resume: got %b required 0010", gnt); end
    tick();
    req = '0;
    for (int i = 0; i < 8; i++) tick();
    n_chk++; if ({res_vld, res} !== {4'b0010, 32'h1234}) begin n_fail++;
      $display("FAIL hold_resume_res: got %b %h required 0010 00001234", res_vld, res); end
    tick(); tick();
  endtask

  initial begin
    test_reset();
    test_single_add();
    test_subtract();
    test_carry_chain();
    test_back_to_back();
    test_hold();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ks_add_sched.md
# ks_add_sched

Round-robin scheduler that shares one pipelined 32-bit Kogge-Stone adder (pg stage, five prefix stages, sum stage) among `NREQ` requesters in the FFT butterfly datapath. It registers the granted operands into the adder, tracks each in-flight operation with a tag pipeline matched to the adder latency, and returns each sum and carry-out to the requester that issued it. Subtraction is handled by operand inversion and carry-in.

## Interface
- `NREQ`, 4: number of requesters, 2..8.
- `LAT`, 7: adder latency in cycles, from `o_add_vld` to the matching `i_add_sum` (pg + 5 prefix + sum).
- `i_clk`  in  1: clock, rising edge.
- `i_rst_n`  in  1: reset, asynchronous, active-low.
- `i_req`  in  NREQ: request per requester. Level, held until granted.
- `i_a`  in  NREQ*32: operand A, requester k at bits [32k+31:32k].
- `i_b`  in  NREQ*32: operand B, same packing as `i_a`.
- `i_sub`  in  NREQ: 1 = A−B, 0 = A+B.
- `i_hold`  in  1: suppresses new grants. In-flight operations still drain.
- `o_gnt`  out  NREQ: one-hot, combinational. Operand accepted this cycle.
- `o_add_a`, `o_add_b`  out  32 each: registered operands to the adder.
- `o_add_cin`  out  1: registered adder carry-in.
- `o_add_vld`  out  1: registered. Operands on `o_add_*` are valid this cycle.
- `i_add_sum`  in  32, `i_add_cout`  in  1: adder result.
- `o_res`  out  32, `o_cout`  out  1: registered result.
- `o_res_vld`  out  NREQ: one-hot, registered. Result belongs to that requester.
- `o_busy`  out  1: registered. Any operation in flight.

## Operation
- **Arbitration**
  - Round-robin pointer `rr` (log2 NREQ bits), reset 0.
  - The winner is the first requester with `i_req` set, searching from `rr` upward and wrapping.
  - `o_gnt` = 0 when `i_hold`=1 or no request is pending.
  - On a grant to requester k, `rr` ← (k+1) mod NREQ. Otherwise `rr` is unchanged.
- **Issue**
  - On a grant to k: `o_add_a` ← `a_k`, `o_add_b` ← `i_sub[k] ? ~b_k : b_k`, `o_add_cin` ← `i_sub[k]`, `o_add_vld` ← 1.
  - With no grant: `o_add_vld` ← 0 and the operand registers hold their values.
- **Tag pipeline**
  - LAT+1 stages of {valid, id}. Stage 0 is loaded with the grant.
  - Stage LAT aligns with `i_add_sum`.
  - When stage LAT is valid: `o_res` ← `i_add_sum`, `o_cout` ← `i_add_cout`, `o_res_vld` ← onehot(id).
  - Otherwise `o_res_vld` ← 0 and `o_res`/`o_cout` hold their values.
- **No backpressure.** Requesters must accept `o_res_vld` in the cycle it is asserted.
- **Arithmetic**
  - Results are modulo 2^32.
  - `o_cout` is the raw adder carry. For subtraction, cout=1 means no borrow (A ≥ B unsigned).
- **Boundaries**
  - All NREQ requesters continuously asserted: one grant per cycle, rotating 0,1,2,…,NREQ−1,0.
  - Back-to-back grants fill the adder at full throughput.
  - `i_hold` rising does not cancel operations already granted.
  - A requester that drops `i_req` before it is granted is simply skipped.
  - `o_busy` = OR of `o_add_vld` and all tag-stage valids, registered.

## Timing
- **Reset values**
  - `o_add_a`, `o_add_b`, `o_res` = 0.
  - `o_add_cin`, `o_cout` = 0.
  - `o_add_vld`, `o_res_vld`, `o_busy` = 0.
  - `rr` = 0 and all tag valids = 0.
- **Reset mid-operation:** all in-flight operations are discarded. No `o_res_vld` is produced for them.
- **Latency** from grant at cycle t:
  - `o_add_vld` is high at t+1.
  - The adder result arrives at t+1+LAT.
  - `o_res_vld` is high at t+2+LAT, i.e. t+9 for LAT=7.
- **Grant** is combinational from `i_req`/`i_hold`/`rr`. Operand capture happens on the same edge that advances `rr`.
- **Throughput:** one operation per cycle. No bubbles are inserted between requesters.

## Test plan
- **Reset:** assert `i_rst_n`=0 mid-stream with 3 ops in flight, then release. Required: all outputs 0, no `o_res_vld` for the 3 dropped ops, first grant goes to requester 0.
- **Single add:** req 2, A=0x7FFF_FFFF, B=1, sub=0. Required: `o_gnt`=4'b0100, then 9 cycles later `o_res_vld`=4'b0100, `o_res`=0x8000_0000, `o_cout`=0.
- **Subtract:** req 1, A=5, B=7, sub=1. Required: adder sees B=0xFFFF_FFF8, cin=1. Result 0xFFFF_FFFE, `o_cout`=0. Repeat with A=7, B=5: result 2, `o_cout`=1.
- **Full contention:** all 4 requesters asserted for 8 cycles with A=id, B=0x100. Required: grants 0,1,2,3,0,1,2,3. Results return in the same order, each `o_res`=0x100+id at 9-cycle offset, with no gaps.
- **Hold:** `i_hold`=1 while requests are pending. Required: no grants, in-flight results still delivered, `o_busy` falls 1 cycle after the last `o_res_vld`. On release, the next grant resumes from `rr`.
- **Carry chain:** A=0xFFFF_FFFF, B=1. Required: `o_res`=0, `o_cout`=1.
